// File: rtl/cpu_sequencer_if.sv
// Handshake bundle between the MU0 sequencer and its surroundings
// (instruction memory, accumulator flags, decoder).
interface cpu_sequencer_if #(parameter int INSTR_CNT_W = 16);
  logic                   run;
  logic [15:0]            mem_q;
  logic                   acc_neg;
  logic                   acc_zero;
  logic                   FETCH;
  logic                   EXEC1;
  logic                   EXEC2;
  logic [15:0]            IR;
  logic [3:0]             OP;
  logic                   jump_taken;
  logic                   halted;
  logic                   illegal;
  logic [INSTR_CNT_W-1:0] instr_count;

  modport master (
    output run, mem_q, acc_neg, acc_zero,
    input  FETCH, EXEC1, EXEC2, IR, OP, jump_taken, halted, illegal, instr_count
  );

  modport slave (
    input  run, mem_q, acc_neg, acc_zero,
    output FETCH, EXEC1, EXEC2, IR, OP, jump_taken, halted, illegal, instr_count
  );
endinterface

// File: rtl/cpu_sequencer.sv
// MU0 control-state generator: FETCH/EXEC1/EXEC2 phase strobes, IR latch,
// jump evaluation, STP halt, illegal-opcode flag and retired-instruction count.
module cpu_sequencer #(
    parameter int          INSTR_CNT_W = 16,
    parameter logic [15:0] EXEC2_MASK  = 16'h0001,
    parameter logic [3:0]  LAST_OPCODE = 4'hA
) (
    input logic            clk,
    input logic            rst_n,
    cpu_sequencer_if.slave bus
);

    typedef enum logic [2:0] {IDLE, S_FETCH, S_EXEC1, S_EXEC2, HALT} state_t;

    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JMI = 4'h5;
    localparam logic [3:0] OP_JEQ = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    state_t     state;
    logic [3:0] op;
    logic       op_illegal;
    logic       needs_exec2;

    assign op          = bus.IR[15:12];
    assign op_illegal  = (op > LAST_OPCODE);
    // Illegal opcodes always run as a single-EXEC1 NOP, whatever the mask says.
    assign needs_exec2 = EXEC2_MASK[op] && !op_illegal;

    assign bus.OP         = op;
    assign bus.illegal    = bus.EXEC1 && op_illegal;
    assign bus.jump_taken = bus.EXEC1 && ((op == OP_JMP) ||
                                          (op == OP_JMI && bus.acc_neg) ||
                                          (op == OP_JEQ && bus.acc_zero));

    // Strobes are loaded with the decode of the next state so they stay
    // registered and one-hot with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.FETCH       <= 1'b0;
            bus.EXEC1       <= 1'b0;
            bus.EXEC2       <= 1'b0;
            bus.IR          <= '0;
            bus.halted      <= 1'b0;
            bus.instr_count <= '0;
        end else begin
            bus.FETCH <= 1'b0;
            bus.EXEC1 <= 1'b0;
            bus.EXEC2 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.run) begin
                        state     <= S_FETCH;
                        bus.FETCH <= 1'b1;
                    end
                end
                S_FETCH: begin
                    bus.IR    <= bus.mem_q;
                    state     <= S_EXEC1;
                    bus.EXEC1 <= 1'b1;
                end
                S_EXEC1: begin
                    if (op == OP_STP) begin
                        state           <= HALT;
                        bus.halted      <= 1'b1;
                        bus.instr_count <= bus.instr_count + INSTR_CNT_W'(1);
                    end else if (needs_exec2) begin
                        state     <= S_EXEC2;
                        bus.EXEC2 <= 1'b1;
                    end else begin
                        bus.instr_count <= bus.instr_count + INSTR_CNT_W'(1);
                        if (bus.run) begin
                            state     <= S_FETCH;
                            bus.FETCH <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                S_EXEC2: begin
                    bus.instr_count <= bus.instr_count + INSTR_CNT_W'(1);
                    if (bus.run) begin
                        state     <= S_FETCH;
                        bus.FETCH <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                HALT: begin
                    if (!bus.run) begin
                        state      <= IDLE;
                        bus.halted <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.halted <= 1'b0;
                end
            endcase
        end
    end

endmodule
